sys_array_os: RTL and testbench

- Next-generation output-stationary systolic matrix-multiply array. It computes C[ROWS x COLS] = A[ROWS x K] * W[K x COLS] over K streamed beats.
- Generalised over the 8-bit/12-bit fixed-size PE grid in data width, accumulator width and depth.
- Adds internal input skewing, a valid/ready input stream, automatic pipeline flush, and a row-serial result drain with backpressure.
- Sits between the operand buffers and the result writeback path.

---
 rtl/sys_array_pkg.sv | 16 +
 rtl/sys_array_os_mac_pe.sv | 48 ++++
 rtl/sys_array_os.sv | 201 ++++++++++++++++++++
 tb/tb_sys_array_os.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/sys_array_pkg.sv
// Shared types and helpers for the output-stationary systolic array.
package sys_array_pkg;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        FLUSH,
        DRAIN
    } state_t;

    // Extra advances needed for the last beat to reach the far corner PE.
    function automatic int flush_len(input int rows, input int cols);
        return rows + cols - 2;
    endfunction

endpackage

// File: rtl/sys_array_os_mac_pe.sv
// One processing element: forwards operands east/south and accumulates
// their signed product in place.
module mac_pe #(
    parameter int DW   = 8,
    parameter int ACCW = 32
) (
    input  logic                   clk,
    input  logic                   rstn,
    input  logic                   adv,
    input  logic                   clr,
    input  logic signed [DW-1:0]   a_in,
    input  logic signed [DW-1:0]   w_in,
    output logic signed [DW-1:0]   a_out,
    output logic signed [DW-1:0]   w_out,
    output logic signed [ACCW-1:0] acc
);

    logic signed [DW-1:0]   a_q;
    logic signed [DW-1:0]   w_q;
    logic signed [ACCW-1:0] acc_q;
    logic signed [ACCW-1:0] acc_d;
    logic signed [2*DW-1:0] prod;

    // Sized cast of a signed value sign-extends; the sum wraps modulo 2^ACCW.
    assign prod  = a_in * w_in;
    assign acc_d = acc_q + ACCW'(prod);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            a_q   <= '0;
            w_q   <= '0;
            acc_q <= '0;
        end else if (clr) begin
            a_q   <= '0;
            w_q   <= '0;
            acc_q <= '0;
        end else if (adv) begin
            a_q   <= a_in;
            w_q   <= w_in;
            acc_q <= acc_d;
        end
    end

    assign a_out = a_q;
    assign w_out = w_q;
    assign acc   = acc_q;

endmodule

// File: rtl/sys_array_os.sv
// Output-stationary systolic matrix multiply C = A * W with internal input
// skew, valid/ready operand stream, automatic flush and row-serial drain.
module sys_array_os
    import sys_array_pkg::*;
#(
    parameter int ROWS = 4,
    parameter int COLS = 4,
    parameter int DW   = 8,
    parameter int ACCW = 32,
    parameter int KW   = 16
) (
    input  logic                   clk,
    input  logic                   rstn,
    input  logic                   start,
    input  logic [KW-1:0]          k_len,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [ROWS*DW-1:0]     in_a,
    input  logic [COLS*DW-1:0]     in_w,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [COLS*ACCW-1:0]   out_data,
    output logic                   out_last,
    output logic                   busy
);

    localparam int FLUSH_LEN = flush_len(ROWS, COLS);
    localparam int FCW       = (FLUSH_LEN > 1) ? $clog2(FLUSH_LEN) : 1;
    localparam int RW        = (ROWS > 1) ? $clog2(ROWS) : 1;

    state_t          state_q;
    logic [KW-1:0]   klen_q;
    logic [KW-1:0]   kcnt_q;
    logic [FCW-1:0]  fcnt_q;
    logic [RW-1:0]   row_q;
    logic            in_ready_q;
    logic            out_valid_q;
    logic            out_last_q;
    logic            busy_q;

    logic adv;
    logic clr;

    logic signed [DW-1:0]   a_bus    [ROWS][COLS+1];
    logic signed [DW-1:0]   w_bus    [ROWS+1][COLS];
    logic signed [ACCW-1:0] acc_grid [ROWS][COLS];

    assign clr = (state_q == IDLE) && start;
    assign adv = ((state_q == LOAD) && in_valid) || (state_q == FLUSH);

    // Lane i of A is delayed i advances; zeros are injected outside LOAD.
    for (genvar i = 0; i < ROWS; i++) begin : g_skew_a
        logic signed [DW-1:0] lane;
        assign lane = (state_q == LOAD) ? in_a[i*DW +: DW] : '0;
        if (i == 0) begin : g_direct
            assign a_bus[i][0] = lane;
        end else begin : g_delay
            logic signed [DW-1:0] sr_q [i];
            always_ff @(posedge clk or negedge rstn) begin
                if (!rstn) begin
                    for (int s = 0; s < i; s++) sr_q[s] <= '0;
                end else if (clr) begin
                    for (int s = 0; s < i; s++) sr_q[s] <= '0;
                end else if (adv) begin
                    sr_q[0] <= lane;
                    for (int s = 1; s < i; s++) sr_q[s] <= sr_q[s-1];
                end
            end
            assign a_bus[i][0] = sr_q[i-1];
        end
    end

    for (genvar j = 0; j < COLS; j++) begin : g_skew_w
        logic signed [DW-1:0] lane;
        assign lane = (state_q == LOAD) ? in_w[j*DW +: DW] : '0;
        if (j == 0) begin : g_direct
            assign w_bus[0][j] = lane;
        end else begin : g_delay
            logic signed [DW-1:0] sr_q [j];
            always_ff @(posedge clk or negedge rstn) begin
                if (!rstn) begin
                    for (int s = 0; s < j; s++) sr_q[s] <= '0;
                end else if (clr) begin
                    for (int s = 0; s < j; s++) sr_q[s] <= '0;
                end else if (adv) begin
                    sr_q[0] <= lane;
                    for (int s = 1; s < j; s++) sr_q[s] <= sr_q[s-1];
                end
            end
            assign w_bus[0][j] = sr_q[j-1];
        end
    end

    for (genvar i = 0; i < ROWS; i++) begin : g_row
        for (genvar j = 0; j < COLS; j++) begin : g_col
            mac_pe #(
                .DW  (DW),
                .ACCW(ACCW)
            ) u_pe (
                .clk  (clk),
                .rstn (rstn),
                .adv  (adv),
                .clr  (clr),
                .a_in (a_bus[i][j]),
                .w_in (w_bus[i][j]),
                .a_out(a_bus[i][j+1]),
                .w_out(w_bus[i+1][j]),
                .acc  (acc_grid[i][j])
            );
        end
    end

    // Control FSM; all handshake outputs are registered alongside the state.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q     <= IDLE;
            klen_q      <= '0;
            kcnt_q      <= '0;
            fcnt_q      <= '0;
            row_q       <= '0;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        klen_q <= k_len;
                        kcnt_q <= '0;
                        fcnt_q <= '0;
                        row_q  <= '0;
                        busy_q <= 1'b1;
                        if (k_len != '0) begin
                            state_q    <= LOAD;
                            in_ready_q <= 1'b1;
                        end else begin
                            state_q     <= DRAIN;
                            out_valid_q <= 1'b1;
                            out_last_q  <= (ROWS == 1);
                        end
                    end
                end
                LOAD: begin
                    if (in_valid) begin
                        if (kcnt_q == klen_q - KW'(1)) begin
                            kcnt_q     <= '0;
                            in_ready_q <= 1'b0;
                            if (FLUSH_LEN == 0) begin
                                state_q     <= DRAIN;
                                out_valid_q <= 1'b1;
                                out_last_q  <= (ROWS == 1);
                            end else begin
                                state_q <= FLUSH;
                                fcnt_q  <= '0;
                            end
                        end else begin
                            kcnt_q <= kcnt_q + KW'(1);
                        end
                    end
                end
                FLUSH: begin
                    if (fcnt_q == FCW'(FLUSH_LEN - 1)) begin
                        state_q     <= DRAIN;
                        out_valid_q <= 1'b1;
                        out_last_q  <= (ROWS == 1);
                    end else begin
                        fcnt_q <= fcnt_q + FCW'(1);
                    end
                end
                DRAIN: begin
                    if (out_ready) begin
                        if (out_last_q) begin
                            state_q     <= IDLE;
                            out_valid_q <= 1'b0;
                            out_last_q  <= 1'b0;
                            busy_q      <= 1'b0;
                            row_q       <= '0;
                        end else begin
                            row_q      <= row_q + RW'(1);
                            out_last_q <= (row_q == RW'(ROWS - 2));
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // The array is frozen during DRAIN, so a mux of the accumulators is stable.
    always_comb begin
        out_data = '0;
        for (int j = 0; j < COLS; j++) out_data[j*ACCW +: ACCW] = acc_grid[row_q][j];
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_last  = out_last_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_sys_array_os.sv
// Directed bench: two 2x2 arrays (32- and 16-bit accumulators) driven in
// lockstep, plus a default 4x4 array, against hand-computed results.
module tb_sys_array_os;

    logic clk  = 1'b0;
    logic rstn = 1'b0;

    logic        start2    = 1'b0;
    logic [15:0] klen2     = '0;
    logic        inValid2  = 1'b0;
    logic [15:0] inA2      = '0;
    logic [15:0] inW2      = '0;
    logic        outReady2 = 1'b0;

    logic        inReadyA, outValidA, outLastA, busyA;
    logic [63:0] outDataA;
    logic        inReadyB, outValidB, outLastB, busyB;
    logic [31:0] outDataB;

    logic         startC    = 1'b0;
    logic [15:0]  klenC     = '0;
    logic         inValidC  = 1'b0;
    logic [31:0]  inAC      = '0;
    logic [31:0]  inWC      = '0;
    logic         outReadyC = 1'b0;
    logic         inReadyC, outValidC, outLastC, busyC;
    logic [127:0] outDataC;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    sys_array_os #(.ROWS(2), .COLS(2), .DW(8), .ACCW(32), .KW(16)) dutA (
        .clk(clk), .rstn(rstn), .start(start2), .k_len(klen2),
        .in_valid(inValid2), .in_ready(inReadyA), .in_a(inA2), .in_w(inW2),
        .out_valid(outValidA), .out_ready(outReady2), .out_data(outDataA),
        .out_last(outLastA), .busy(busyA)
    );

    sys_array_os #(.ROWS(2), .COLS(2), .DW(8), .ACCW(16), .KW(16)) dutB (
        .clk(clk), .rstn(rstn), .start(start2), .k_len(klen2),
        .in_valid(inValid2), .in_ready(inReadyB), .in_a(inA2), .in_w(inW2),
        .out_valid(outValidB), .out_ready(outReady2), .out_data(outDataB),
        .out_last(outLastB), .busy(busyB)
    );

    sys_array_os #(.ROWS(4), .COLS(4), .DW(8), .ACCW(32), .KW(16)) dutC (
        .clk(clk), .rstn(rstn), .start(startC), .k_len(klenC),
        .in_valid(inValidC), .in_ready(inReadyC), .in_a(inAC), .in_w(inWC),
        .out_valid(outValidC), .out_ready(outReadyC), .out_data(outDataC),
        .out_last(outLastC), .busy(busyC)
    );

    task automatic checkOutput(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic startJob2(input logic [15:0] k);
        start2 = 1'b1;
        klen2  = k;
        tick();
        start2 = 1'b0;
    endtask

    task automatic applyStimulus(input logic [15:0] a, input logic [15:0] w);
        checkOutput("beat_ready", inReadyA, 1'b1);
        inValid2 = 1'b1;
        inA2     = a;
        inW2     = w;
        tick();
        inValid2 = 1'b0;
    endtask

    task automatic drainRow2(input string tag, input logic [63:0] expA, input logic [31:0] expB,
                             input logic expLast, input int stall);
        checkOutput({tag, "_validA"}, outValidA, 1'b1);
        checkOutput({tag, "_validB"}, outValidB, 1'b1);
        checkOutput({tag, "_dataA"}, outDataA, expA);
        checkOutput({tag, "_dataB"}, outDataB, expB);
        checkOutput({tag, "_last"}, outLastA, expLast);
        for (int s = 0; s < stall; s++) begin
            tick();
            checkOutput({tag, "_holdValid"}, outValidA, 1'b1);
            checkOutput({tag, "_holdData"}, outDataA, expA);
            checkOutput({tag, "_holdLast"}, outLastA, expLast);
        end
        outReady2 = 1'b1;
        tick();
        outReady2 = 1'b0;
    endtask

    task automatic applyStimulusWide(input logic [31:0] a, input logic [31:0] w);
        checkOutput("wide_ready", inReadyC, 1'b1);
        inValidC = 1'b1;
        inAC     = a;
        inWC     = w;
        tick();
        inValidC = 1'b0;
    endtask

    task automatic drainRowWide(input string tag, input logic [127:0] exp, input logic expLast);
        checkOutput({tag, "_valid"}, outValidC, 1'b1);
        checkOutput({tag, "_data"}, outDataC, exp);
        checkOutput({tag, "_last"}, outLastC, expLast);
        outReadyC = 1'b1;
        tick();
        outReadyC = 1'b0;
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: got timeout expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [31:0]  wv;
        logic [127:0] rowExp;

        #12;
        checkOutput("rst_busy", busyA, 1'b0);
        checkOutput("rst_ready", inReadyA, 1'b0);
        checkOutput("rst_valid", outValidA, 1'b0);
        checkOutput("rst_last", outLastA, 1'b0);
        checkOutput("rst_data", outDataA, 64'd0);
        checkOutput("rst_busyC", busyC, 1'b0);
        #1 rstn = 1'b1;
        tick();

        // 4x4 identity times W[k][j] = 4k+j
        startC = 1'b1;
        klenC  = 16'd4;
        tick();
        startC = 1'b0;
        checkOutput("id_busy", busyC, 1'b1);
        for (int k = 0; k < 4; k++) begin
            for (int j = 0; j < 4; j++) wv[j*8 +: 8] = 8'(4*k + j);
            applyStimulusWide(32'd1 << (8*k), wv);
        end
        repeat (5) tick();
        checkOutput("id_lat", outValidC, 1'b0);
        tick();
        for (int r = 0; r < 4; r++) begin
            for (int j = 0; j < 4; j++) rowExp[j*32 +: 32] = 32'(4*r + j);
            drainRowWide("id_row", rowExp, r == 3);
        end
        checkOutput("id_idle", busyC, 1'b0);

        // 2x2 basic job
        startJob2(16'd2);
        checkOutput("s1_busy", busyA, 1'b1);
        applyStimulus(16'h0301, 16'h0605);
        applyStimulus(16'h0402, 16'h0807);
        checkOutput("s1_lat0", outValidA, 1'b0);
        checkOutput("s1_flushReady", inReadyA, 1'b0);
        tick();
        checkOutput("s1_lat1", outValidA, 1'b0);
        tick();
        drainRow2("s1_r0", {32'd22, 32'd19}, {16'd22, 16'd19}, 1'b0, 0);
        drainRow2("s1_r1", {32'd50, 32'd43}, {16'd50, 16'd43}, 1'b1, 0);
        checkOutput("s1_busyOff", busyA, 1'b0);
        checkOutput("s1_validOff", outValidA, 1'b0);

        // Same job back-to-back with input stalls, ignored start and output backpressure
        startJob2(16'd2);
        checkOutput("st_busy", busyA, 1'b1);
        applyStimulus(16'h0301, 16'h0605);
        inA2   = 16'h7F7F;
        inW2   = 16'h7F7F;
        start2 = 1'b1;
        klen2  = 16'd0;
        tick();
        start2 = 1'b0;
        checkOutput("st_ready1", inReadyA, 1'b1);
        checkOutput("st_valid1", outValidA, 1'b0);
        tick();
        checkOutput("st_ready2", inReadyA, 1'b1);
        applyStimulus(16'h0402, 16'h0807);
        tick();
        tick();
        drainRow2("st_r0", {32'd22, 32'd19}, {16'd22, 16'd19}, 1'b0, 3);
        drainRow2("st_r1", {32'd50, 32'd43}, {16'd50, 16'd43}, 1'b1, 3);
        checkOutput("st_busyOff", busyA, 1'b0);

        // All operands -128: 4 * 16384 = 65536, wraps to 0 in 16 bits
        startJob2(16'd4);
        for (int k = 0; k < 4; k++) applyStimulus(16'h8080, 16'h8080);
        tick();
        tick();
        drainRow2("wr_r0", {32'd65536, 32'd65536}, 32'd0, 1'b0, 0);
        drainRow2("wr_r1", {32'd65536, 32'd65536}, 32'd0, 1'b1, 0);

        // k_len = 0 goes straight to DRAIN with cleared results
        startJob2(16'd0);
        checkOutput("kz_ready", inReadyA, 1'b0);
        drainRow2("kz_r0", 64'd0, 32'd0, 1'b0, 0);
        drainRow2("kz_r1", 64'd0, 32'd0, 1'b1, 0);
        checkOutput("kz_busyOff", busyA, 1'b0);

        // Reset during FLUSH aborts the job
        startJob2(16'd2);
        applyStimulus(16'h0505, 16'h0505);
        applyStimulus(16'h0505, 16'h0505);
        checkOutput("ab_busyOn", busyA, 1'b1);
        #2 rstn = 1'b0;
        #1;
        checkOutput("ab_busy", busyA, 1'b0);
        checkOutput("ab_valid", outValidA, 1'b0);
        checkOutput("ab_ready", inReadyA, 1'b0);
        checkOutput("ab_data", outDataA, 64'd0);
        #3 rstn = 1'b1;
        tick();
        startJob2(16'd2);
        applyStimulus(16'h0301, 16'h0605);
        applyStimulus(16'h0402, 16'h0807);
        tick();
        tick();
        drainRow2("ar_r0", {32'd22, 32'd19}, {16'd22, 16'd19}, 1'b0, 0);
        drainRow2("ar_r1", {32'd50, 32'd43}, {16'd50, 16'd43}, 1'b1, 0);
        checkOutput("ar_busyOff", busyA, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
